axi2mem_tcdm_resp: RTL



---
 rtl/axi2mem_tcdm_resp_pkg.sv | 30 +++
 rtl/axi2mem_tcdm_resp_if.sv | 24 ++
 rtl/axi2mem_tcdm_resp_pipe.sv | 30 +++
 rtl/axi2mem_tcdm_resp.sv | 94 +++++++++
 4 files changed

// File: rtl/axi2mem_tcdm_resp_pkg.sv
// Shared TCDM widths, request/response records and byte-enable helper for the axi2mem TCDM responder.
package axi2mem_tcdm_pkg;

    localparam int unsigned TCDM_AW  = 32;
    localparam int unsigned TCDM_DW  = 32;
    localparam int unsigned TCDM_BEW = 4;

    typedef struct packed {
        logic [TCDM_AW-1:0]  add;
        logic                we;
        logic [TCDM_DW-1:0]  wdata;
        logic [TCDM_BEW-1:0] be;
    } tcdm_req_t;

    typedef struct packed {
        logic [TCDM_DW-1:0] rdata;
        logic               valid;
    } tcdm_resp_t;

    // Expands one enable bit per byte lane into a full-width bit mask.
    function automatic logic [TCDM_DW-1:0] be_mask(input logic [TCDM_BEW-1:0] be);
        logic [TCDM_DW-1:0] mask;
        mask = '0;
        for (int n = 0; n < int'(TCDM_BEW); n++) begin
            mask[8*n +: 8] = {8{be[n]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi2mem_tcdm_resp_if.sv
// TCDM request/grant/r_valid bundle; master = initiator side, slave = memory side.
interface axi2mem_tcdm_resp_if;
    import axi2mem_tcdm_pkg::*;

    logic                req;
    logic [TCDM_AW-1:0]  add;
    logic                we;
    logic [TCDM_DW-1:0]  wdata;
    logic [TCDM_BEW-1:0] be;
    logic                gnt;
    logic [TCDM_DW-1:0]  r_rdata;
    logic                r_valid;

    modport master (
        output req, add, we, wdata, be,
        input  gnt, r_rdata, r_valid
    );

    modport slave (
        input  req, add, we, wdata, be,
        output gnt, r_rdata, r_valid
    );

endinterface

// File: rtl/axi2mem_tcdm_resp_pipe.sv
// Fixed-latency response shift register; reset clears every stage so in-flight responses are dropped.
module axi2mem_tcdm_resp_pipe
    import axi2mem_tcdm_pkg::*;
#(
    parameter int unsigned RESP_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  tcdm_resp_t resp_in,
    output tcdm_resp_t resp_out
);

    tcdm_resp_t stage_q [RESP_LAT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(RESP_LAT); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_in;
            for (int i = 1; i < int'(RESP_LAT); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_out = stage_q[RESP_LAT-1];

endmodule

// File: rtl/axi2mem_tcdm_resp.sv
// TCDM memory-side responder: word-addressed scratchpad with byte-enable writes and fixed response latency.
// Optional grant stall every STALL_PERIOD cycles when AXI2MEM_TCDM_STALL_EN is defined.
module axi2mem_tcdm_resp
    import axi2mem_tcdm_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned RESP_LAT     = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned STALL_PERIOD = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axi2mem_tcdm_resp_if.slave tcdm
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    if (MEM_WORDS < 4 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
        $error("MEM_WORDS must be a power of two, at least 4");
    end
    if (RESP_LAT < 1 || RESP_LAT > 4) begin : g_bad_resp_lat
        $error("RESP_LAT must be in 1..4");
    end
    if (STALL_PERIOD < 2 || STALL_PERIOD > 16) begin : g_bad_stall_period
        $error("STALL_PERIOD must be in 2..16");
    end

    tcdm_req_t          req_s;
    logic               stall;
    logic               accept;
    logic [IDX_W-1:0]   idx;
    logic [TCDM_DW-1:0] wmask;
    logic [TCDM_DW-1:0] mem [MEM_WORDS];
    tcdm_resp_t         resp_in;
    tcdm_resp_t         resp_out;

    assign req_s.add   = tcdm.add;
    assign req_s.we    = tcdm.we;
    assign req_s.wdata = tcdm.wdata;
    assign req_s.be    = tcdm.be;

`ifdef AXI2MEM_TCDM_STALL_EN
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_q == 4'(STALL_PERIOD - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign stall = (cnt_q == 4'(STALL_PERIOD - 1));
`else
    assign stall = 1'b0;
`endif

    // Grant follows req even in reset; acceptance is what reset suppresses.
    assign tcdm.gnt = tcdm.req & ~stall;
    assign accept   = tcdm.req & tcdm.gnt & ~rst_i;

    // Wrapping offset from BASE_ADDR; byte bits and bits above the index alias away.
    assign idx   = IDX_W'((req_s.add - BASE_ADDR) >> 2);
    assign wmask = be_mask(req_s.be);

    always_ff @(posedge clk_i) begin
        if (accept && req_s.we) begin
            mem[idx] <= (mem[idx] & ~wmask) | (req_s.wdata & wmask);
        end
    end

    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        if (accept && !req_s.we) begin
            resp_in.rdata = mem[idx];
        end
    end

    axi2mem_tcdm_resp_pipe #(
        .RESP_LAT (RESP_LAT)
    ) u_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .resp_in  (resp_in),
        .resp_out (resp_out)
    );

    assign tcdm.r_valid = resp_out.valid;
    assign tcdm.r_rdata = resp_out.rdata;

endmodule
